vga_text_scanout: RTL and testbench
===================================

// Module: vga_text_scanout
// PURPOSE
//  Reader side of the video character RAM that the memory controller writes (CPU 0xF82F-0xFFFE, 2000 words).
//  Scans an 80x25 text screen and fetches one character word per 8 pixels.
//  Looks each glyph up in an 8x16 font ROM and emits a 640x480@60 VGA pixel/sync stream.
//  Runs on the pixel clock (clk = 25.175 MHz nominal). Colour index to DAC mapping is outside this block.
// PARAMETERS
//  H_VIS 640, H_FP 16, H_SYNC 96, H_BP 48    horizontal timing, pixels (total 800)
//  V_VIS 480, V_FP 10, V_SYNC 2,  V_BP 33    vertical timing, lines (total 525)
//  TEXT_COLS 80, TEXT_ROWS 25                text grid; glyph cell is 8x16
//  SYNC_POL 0                                active level of hsync/vsync (0 = active-low)
// PORTS
//  clk             in   1   pixel clock; single clock domain
//  rst             in   1   synchronous reset, active-high
//  video_ram_addr  out  12  character RAM word address, 0..1999
//  video_ram_data  in   16  [7:0] char code, [11:8] fg index, [15:12] bg index; valid 1 cycle after addr
//  font_addr       out  12  {char[7:0], glyph_line[3:0]}
//  font_data       in   8   glyph row, bit7 = leftmost pixel; valid 1 cycle after addr
//  pixel_color     out  4   IRGB colour index for the current pixel
//  vga_hsync       out  1   horizontal sync
//  vga_vsync       out  1   vertical sync
//  vga_de          out  1   display enable (640x480 active area)
//  frame_start     out  1   1-cycle pulse when pixel (0,0) is presented
// BEHAVIOUR
//  Counters: h_cnt 0..799 increments every clk and wraps to 0. v_cnt 0..524 increments when h_cnt wraps, then wraps to 0.
//  Text area: h_cnt<640 and v_cnt<400. col=h_cnt[9:3], glyph_line=v_cnt[3:0].
//  row_base register: +80 when v_cnt[3:0]==15 at h_cnt==799 (v_cnt<400); 0 at frame wrap. No multiplier.
//  Pipeline, stage T = cycle where h_cnt holds pixel h:
//   T+0: if text area and h_cnt[2:0]==0, drive video_ram_addr = row_base+col (held otherwise).
//   T+1: capture attribute; drive font_addr = {video_ram_data[7:0], glyph_line}.
//   T+2: load 8-bit shift reg with font_data (registered at T+3).
//   T+3: present pixel. Shift reg bit7 set -> fg, else bg. Shift left 1 per clk.
//   Attribute is carried with the shift reg.
//  Latency fixed at 3 clk: hsync, vsync, de and frame_start are derived from h_cnt/v_cnt, then delayed 3 stages.
//  This keeps every output aligned to pixel_color.
//  hsync active for h in [656,751]; vsync active for lines [490,491]; de = h<640 && v<480.
//  Outside the text area (v 400..479) de=1 and pixel_color=0. When de=0, pixel_color=0.
//  video_ram_addr never exceeds 1999; no fetch is issued outside the text area.
//  Reset values: h_cnt=v_cnt=0, row_base=0, all pipeline stages cleared.
//  Reset outputs: video_ram_addr=0, font_addr=0, pixel_color=0, de=0, frame_start=0, hsync=vsync=~SYNC_POL (inactive).
//  Reset mid-frame: all state cleared in the same cycle. The first cycle after rst deasserts is h=v=0 with a fetch of addr 0.
//  No stale pixels survive reset; frame_start pulses 3 clk after release.
//  Video RAM is written asynchronously by the CPU. No tearing protection: a word changed mid-frame shows on the next fetch.
// TESTING
//  1. Hold rst 5 clk, release -> cycle 0 addr=0, cycle 1 font_addr={char,4'h0}, cycle 3 frame_start=1 and de=1;
//     during reset hsync=vsync=1, de=0.
//  2. Free-run 2 frames -> 800 clk/line, hsync low 96 clk starting h=656 (+3); vsync low 2 lines at 490; frame_start every 420000 clk.
//  3. Word 0x1F41 at addr 0, font returns 0x81 -> pixels 0..7 = F,1,1,1,1,1,1,F; font_addr=0x410 on line 0.
//  4. Line 21, h=0 -> video_ram_addr=80, font_addr low nibble=5; line 399, h=632 -> addr 1999.
//     Lines 400-479 -> no new addr, de=1, pixel_color=0.
//  5. Assert rst at v=200, h=300 for 1 clk -> next cycle counters 0, outputs at reset values.
//     Following frame timing identical to test 2.
//  6. Change word at addr 5 mid-frame (line 100) -> new glyph appears from next fetch of that cell (line 112 row 7 unaffected).

Source files
------------

// File: rtl/vga_text_scanout.sv
// 80x25 text-mode scanout: walks a 640x480@60 raster, fetches one character word per
// 8-pixel cell, looks up the glyph row in the font ROM and presents pixels 3 clocks later.
`timescale 1ns/1ps
module vga_text_scanout #(
   parameter int   H_VIS     = 640,
   parameter int   H_FP      = 16,
   parameter int   H_SYNC    = 96,
   parameter int   H_BP      = 48,
   parameter int   V_VIS     = 480,
   parameter int   V_FP      = 10,
   parameter int   V_SYNC    = 2,
   parameter int   V_BP      = 33,
   parameter int   TEXT_COLS = 80,
   parameter int   TEXT_ROWS = 25,
   parameter logic SYNC_POL  = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   output logic [11:0] video_ram_addr,
   input  logic [15:0] video_ram_data,
   output logic [11:0] font_addr,
   input  logic [7:0]  font_data,
   output logic [3:0]  pixel_color,
   output logic        vga_hsync,
   output logic        vga_vsync,
   output logic        vga_de,
   output logic        frame_start
);

   localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

   localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0]  H_VIS_W  = 10'(H_VIS);
   localparam logic [9:0]  V_VIS_W  = 10'(V_VIS);
   localparam logic [9:0]  H_TEXT   = 10'(TEXT_COLS * 8);
   localparam logic [9:0]  V_TEXT   = 10'(TEXT_ROWS * 16);
   localparam logic [9:0]  HS_START = 10'(H_VIS + H_FP);
   localparam logic [9:0]  HS_END   = 10'(H_VIS + H_FP + H_SYNC);
   localparam logic [9:0]  VS_START = 10'(V_VIS + V_FP);
   localparam logic [9:0]  VS_END   = 10'(V_VIS + V_FP + V_SYNC);
   localparam logic [10:0] ROW_STEP = 11'(TEXT_COLS);

   // Raster position and first word address of the current text row
   logic [9:0]  h_cnt;
   logic [9:0]  v_cnt;
   logic [10:0] row_base;

   // Stage T+0 decode
   logic        line_end;
   logic        frame_end;
   logic        text_s0;
   logic        fetch_s0;
   logic        de_s0;
   logic        hs_s0;
   logic        vs_s0;
   logic        fs_s0;
   logic [11:0] fetch_addr;
   logic [11:0] addr_q;

   // Stage T+1 / T+2
   logic        fetch_s1;
   logic        fetch_s2;
   logic [3:0]  line_s1;
   logic [11:0] font_addr_q;
   logic [7:0]  attr_s2;

   // Stage T+3 (presentation)
   logic [7:0]  shreg;
   logic [7:0]  attr_s3;
   logic [2:0]  text_pipe;
   logic [2:0]  de_pipe;
   logic [2:0]  hs_pipe;
   logic [2:0]  vs_pipe;
   logic [2:0]  fs_pipe;

   always_comb begin
      // NOTE: every signal gets a value on every path through this block, so no latch can form.
      line_end   = (h_cnt == H_LAST);
      frame_end  = line_end && (v_cnt == V_LAST);
      text_s0    = (h_cnt < H_TEXT) && (v_cnt < V_TEXT);
      fetch_s0   = text_s0 && (h_cnt[2:0] == 3'd0);
      fetch_addr = {1'b0, row_base} + {5'd0, h_cnt[9:3]};
      de_s0      = (h_cnt < H_VIS_W) && (v_cnt < V_VIS_W);
      hs_s0      = ~SYNC_POL;
      vs_s0      = ~SYNC_POL;
      if ((h_cnt >= HS_START) && (h_cnt < HS_END)) hs_s0 = SYNC_POL;
      if ((v_cnt >= VS_START) && (v_cnt < VS_END)) vs_s0 = SYNC_POL;
      fs_s0      = (h_cnt == 10'd0) && (v_cnt == 10'd0);
   end

   // Raster counters; row_base steps by one text row instead of multiplying row*cols.
   always_ff @(posedge clk) begin
      // NOTE: registered state uses non-blocking assignments so all flops update together at the edge.
      if (rst) begin
         h_cnt    <= 10'd0;
         v_cnt    <= 10'd0;
         row_base <= 11'd0;
      end else begin
         if (line_end) begin
            h_cnt <= 10'd0;
            v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
         end else begin
            h_cnt <= h_cnt + 10'd1;
         end

         if (frame_end) begin
            row_base <= 11'd0;
         end else if (line_end && (v_cnt < V_TEXT) && (v_cnt[3:0] == 4'hF)) begin
            row_base <= row_base + ROW_STEP;
         end
      end
   end

   // Character fetch, glyph fetch and pixel shift pipeline
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q      <= 12'd0;
         fetch_s1    <= 1'b0;
         fetch_s2    <= 1'b0;
         line_s1     <= 4'd0;
         font_addr_q <= 12'd0;
         attr_s2     <= 8'd0;
         shreg       <= 8'd0;
         attr_s3     <= 8'd0;
         text_pipe   <= 3'd0;
         de_pipe     <= 3'd0;
         hs_pipe     <= {3{~SYNC_POL}};
         vs_pipe     <= {3{~SYNC_POL}};
         fs_pipe     <= 3'd0;
      end else begin
         if (fetch_s0) addr_q <= fetch_addr;
         fetch_s1 <= fetch_s0;
         fetch_s2 <= fetch_s1;
         line_s1  <= v_cnt[3:0];

         if (fetch_s1) begin
            font_addr_q <= font_addr;
            attr_s2     <= video_ram_data[15:8];
         end

         // Attribute travels with the glyph row so a cell's colours switch with its pixels.
         if (fetch_s2) begin
            shreg   <= font_data;
            attr_s3 <= attr_s2;
         end else begin
            shreg   <= {shreg[6:0], 1'b0};
         end

         text_pipe <= {text_pipe[1:0], text_s0};
         de_pipe   <= {de_pipe[1:0], de_s0};
         hs_pipe   <= {hs_pipe[1:0], hs_s0};
         vs_pipe   <= {vs_pipe[1:0], vs_s0};
         fs_pipe   <= {fs_pipe[1:0], fs_s0};
      end
   end

   // Address ports are live on their issue cycle so the synchronous RAM/ROM answer one clock later.
   assign video_ram_addr = fetch_s0 ? fetch_addr : addr_q;
   assign font_addr      = fetch_s1 ? {video_ram_data[7:0], line_s1} : font_addr_q;

   assign pixel_color = text_pipe[2] ? (shreg[7] ? attr_s3[3:0] : attr_s3[7:4]) : 4'h0;
   assign vga_hsync   = hs_pipe[2];
   assign vga_vsync   = vs_pipe[2];
   assign vga_de      = de_pipe[2];
   assign frame_start = fs_pipe[2];

endmodule

// File: tb/tb_vga_text_scanout.sv
// Bench for vga_text_scanout: a full 640x480 instance and a shrunken-raster instance run side by
// side against a position-arithmetic model; random character RAM writes land mid-frame.
`timescale 1ns/1ps
module tb_vga_text_scanout;

   typedef struct {
      int h_vis, h_fp, h_sync, h_bp;
      int v_vis, v_fp, v_sync, v_bp;
      int cols, rows;
   } geom_t;

   typedef struct {
      int          cyc;
      int          addr;
      logic [15:0] data;
   } ev_t;

   localparam int S_HVIS = 64, S_HFP = 4, S_HSYNC = 8, S_HBP = 4;   // 80 clocks per line
   localparam int S_VVIS = 48, S_VFP = 2, S_VSYNC = 2, S_VBP = 3;   // 55 lines per frame
   localparam int S_COLS = 8,  S_ROWS = 2;

   logic clk;
   logic rst;

   logic [11:0] full_addr, full_font, small_addr, small_font;
   logic [15:0] full_ram_data, small_ram_data;
   logic [7:0]  full_font_data, small_font_data;
   logic [3:0]  full_pix, small_pix;
   logic        full_hs, full_vs, full_de, full_fs;
   logic        small_hs, small_vs, small_de, small_fs;

   logic [15:0] vram      [0:4095];
   logic [15:0] vram_init [0:4095];
   logic [7:0]  font      [0:4095];
   logic [3:0]  glyph_exp [0:7];
   ev_t         ev_q[$];

   geom_t g_full, g_small;
   int    t, g, phase, fs_count, n_checks, n_fail;
   logic  started;

   vga_text_scanout u_full (
      .clk(clk), .rst(rst),
      .video_ram_addr(full_addr), .video_ram_data(full_ram_data),
      .font_addr(full_font), .font_data(full_font_data),
      .pixel_color(full_pix), .vga_hsync(full_hs), .vga_vsync(full_vs),
      .vga_de(full_de), .frame_start(full_fs)
   );

   vga_text_scanout #(
      .H_VIS(S_HVIS), .H_FP(S_HFP), .H_SYNC(S_HSYNC), .H_BP(S_HBP),
      .V_VIS(S_VVIS), .V_FP(S_VFP), .V_SYNC(S_VSYNC), .V_BP(S_VBP),
      .TEXT_COLS(S_COLS), .TEXT_ROWS(S_ROWS), .SYNC_POL(1'b0)
   ) u_small (
      .clk(clk), .rst(rst),
      .video_ram_addr(small_addr), .video_ram_data(small_ram_data),
      .font_addr(small_font), .font_data(small_font_data),
      .pixel_color(small_pix), .vga_hsync(small_hs), .vga_vsync(small_vs),
      .vga_de(small_de), .frame_start(small_fs)
   );

   initial clk = 1'b0;
   always #20 clk = ~clk;

   // Synchronous character RAM and font ROM, one clock of read latency each
   always @(posedge clk) begin
      full_ram_data   <= vram[full_addr];
      small_ram_data  <= vram[small_addr];
      full_font_data  <= font[full_font];
      small_font_data <= font[small_font];
   end

   // t = clocks since the last sampled reset (0 is the h=v=0 cycle); g never resets
   always @(posedge clk) begin
      g <= g + 1;
      if (rst) begin
         t       <= 0;
         started <= 1'b1;
      end else begin
         t <= t + 1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s t=%0d actual=%h required=%h", name, t, act, exp);
      end
   endtask

   function automatic int h_tot(input geom_t gm);
      return gm.h_vis + gm.h_fp + gm.h_sync + gm.h_bp;
   endfunction

   function automatic int v_tot(input geom_t gm);
      return gm.v_vis + gm.v_fp + gm.v_sync + gm.v_bp;
   endfunction

   function automatic int h_of(input geom_t gm, input int c);
      return c % h_tot(gm);
   endfunction

   function automatic int v_of(input geom_t gm, input int c);
      return (c / h_tot(gm)) % v_tot(gm);
   endfunction

   function automatic int cell_of(input geom_t gm, input int c);
      return (v_of(gm, c) / 16) * gm.cols + h_of(gm, c) / 8;
   endfunction

   // Most recent cycle <= c on which a character fetch was issued
   function automatic int last_fetch(input geom_t gm, input int c);
      int h, v, th, tv, hh;
      h  = h_of(gm, c);
      v  = v_of(gm, c);
      th = gm.cols * 8;
      tv = gm.rows * 16;
      if (v < tv) begin
         hh = (h < th) ? h - (h % 8) : th - 8;
         return c - h + hh;
      end
      return c - (c % (h_tot(gm) * v_tot(gm))) + (tv - 1) * h_tot(gm) + th - 8;
   endfunction

   // RAM contents as seen by a read sampled at the end of global cycle gc
   function automatic logic [15:0] word_at(input int a, input int gc);
      logic [15:0] w;
      w = vram_init[a];
      foreach (ev_q[i]) if (ev_q[i].cyc <= gc && ev_q[i].addr == a) w = ev_q[i].data;
      return w;
   endfunction

   // Packed {video_ram_addr, font_addr, pixel_color, hsync, vsync, de, frame_start}
   function automatic logic [31:0] expect_out(input geom_t gm, input int tc, input int gnow);
      int          f, p, ph, pv;
      logic [11:0] e_addr, e_font;
      logic [3:0]  e_pix;
      logic        e_hs, e_vs, e_de, e_fs;
      logic [15:0] w;
      logic [7:0]  row;
      e_addr = 12'(cell_of(gm, last_fetch(gm, tc)));
      e_font = 12'd0;
      if (tc > 0) begin
         f      = last_fetch(gm, tc - 1);
         w      = word_at(cell_of(gm, f), gnow - tc + f);
         e_font = {w[7:0], 4'(v_of(gm, f))};
      end
      e_pix = 4'h0;
      e_hs  = 1'b1;
      e_vs  = 1'b1;
      e_de  = 1'b0;
      e_fs  = 1'b0;
      p     = tc - 3;
      if (p >= 0) begin
         ph   = h_of(gm, p);
         pv   = v_of(gm, p);
         e_de = (ph < gm.h_vis) && (pv < gm.v_vis);
         e_hs = !((ph >= gm.h_vis + gm.h_fp) && (ph < gm.h_vis + gm.h_fp + gm.h_sync));
         e_vs = !((pv >= gm.v_vis + gm.v_fp) && (pv < gm.v_vis + gm.v_fp + gm.v_sync));
         e_fs = (ph == 0) && (pv == 0);
         if (ph < gm.cols * 8 && pv < gm.rows * 16) begin
            f     = p - (ph % 8);
            w     = word_at(cell_of(gm, f), gnow - tc + f);
            row   = font[{w[7:0], 4'(pv)}];
            e_pix = row[7 - (ph % 8)] ? w[11:8] : w[15:12];
         end
      end
      return {e_addr, e_font, e_pix, e_hs, e_vs, e_de, e_fs};
   endfunction

   // Every-cycle model comparison plus hand-computed anchor points
   always @(negedge clk) begin
      if (started) begin
         check("full_outputs",
               {full_addr, full_font, full_pix, full_hs, full_vs, full_de, full_fs},
               expect_out(g_full, t, g));
         check("small_outputs",
               {small_addr, small_font, small_pix, small_hs, small_vs, small_de, small_fs},
               expect_out(g_small, t, g));

         if (phase == 0) begin
            if (t == 0) check("first_addr", full_addr, 12'd0);
            if (t == 1) check("font_addr_0x410", full_font, 12'h410);
            if (t == 3) begin
               check("first_frame_start", full_fs, 1);
               check("first_de", full_de, 1);
            end
            if (t >= 3 && t <= 10) check("glyph_0x81_pixels", full_pix, glyph_exp[t - 3]);
            if (t == 658) check("hsync_before_656", full_hs, 1);
            if (t == 659) check("hsync_at_656", full_hs, 0);
            if (t == 754) check("hsync_at_751", full_hs, 0);
            if (t == 755) check("hsync_after_751", full_hs, 1);
            if (t == 21 * 800) check("line21_addr", full_addr, 12'd80);
            if (t == 21 * 800 + 1) check("line21_glyph_line", full_font[3:0], 4'd5);
            if (t == 31 * 80 + 56) check("small_last_cell_addr", small_addr, 12'd15);
            if (t == 40 * 80 + 20) begin
               check("small_below_text_addr", small_addr, 12'd15);
               check("small_below_text_de", small_de, 1);
               check("small_below_text_pixel", small_pix, 4'h0);
            end
            if (t == 49 * 80 + 82) check("small_vsync_line49", small_vs, 1);
            if (t == 50 * 80 + 3)  check("small_vsync_line50", small_vs, 0);
            if (t == 52 * 80 + 3)  check("small_vsync_line52", small_vs, 1);
         end else begin
            if (small_fs) fs_count++;
            if (t == 0) begin
               check("midreset_addr", small_addr, 12'd0);
               check("midreset_de", small_de, 0);
               check("midreset_hsync", small_hs, 1);
               check("midreset_pixel", small_pix, 4'h0);
            end
            if (t == 3) check("midreset_frame_start", small_fs, 1);
         end
      end
   end

   task automatic write_word(input int a, input logic [15:0] d);
      ev_t e;
      vram[a] = d;
      e.cyc   = g;
      e.addr  = a;
      e.data  = d;
      ev_q.push_back(e);
   endtask

   initial begin
      logic found;
      g_full  = '{640, 16, 96, 48, 480, 10, 2, 33, 80, 25};
      g_small = '{S_HVIS, S_HFP, S_HSYNC, S_HBP, S_VVIS, S_VFP, S_VSYNC, S_VBP, S_COLS, S_ROWS};
      glyph_exp = '{4'hF, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'hF};
      n_checks = 0;
      n_fail   = 0;
      fs_count = 0;
      phase    = 0;
      t        = 0;
      g        = 0;
      started  = 1'b0;
      for (int i = 0; i < 4096; i++) begin
         vram[i] = 16'($urandom);
         font[i] = 8'($urandom);
      end
      vram[0]    = 16'h1F41;
      font[12'h410] = 8'h81;
      for (int i = 0; i < 4096; i++) vram_init[i] = vram[i];

      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("reset_hsync", full_hs, 1);
      check("reset_vsync", full_vs, 1);
      check("reset_de", full_de, 0);
      check("reset_frame_start", full_fs, 0);
      check("reset_pixel", full_pix, 4'h0);
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Free run with sporadic asynchronous character RAM writes
      for (int i = 0; i < 20000; i++) begin
         @(negedge clk);
         if (t == 2500) write_word(5, 16'($urandom));
         else if (t > 100 && $urandom_range(0, 399) == 0) begin
            if ($urandom_range(0, 1) == 0) write_word($urandom_range(0, 15), 16'($urandom));
            else write_word($urandom_range(0, 1999), 16'($urandom));
         end
      end

      // One-clock reset landing on line 20, pixel 30 of the small raster
      found = 1'b0;
      for (int i = 0; i < 5000 && !found; i++) begin
         @(negedge clk);
         if (t % 80 == 30 && (t / 80) % 55 == 20) found = 1'b1;
      end
      check("midreset_window_found", found, 1);
      rst   = 1'b1;
      phase = 1;
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 9000 && t < 2 * 4400 + 10; i++) @(negedge clk);
      check("midreset_frame_start_count", fs_count, 3);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
